// File: rtl/pipeline_ifp_gen.sv
// Instruction-fetch-prepare PC generator: owns the fetch PC, issues epoch-tagged
// fetch requests to one of NUM_CH memory channels and bounds outstanding requests.
`ifndef DRAM_BASE_ADDR
`define DRAM_BASE_ADDR 64'h0000_0000_8000_0000
`endif

module pipeline_ifp_gen #(
  parameter int                       XLEN       = 64,
  parameter logic [XLEN-1:0]          RESET_PC   = '0,
  parameter int                       PC_STEP    = 4,
  parameter int                       NUM_CH     = 2,
  parameter logic [NUM_CH*XLEN-1:0]   CH_BASE    = {`DRAM_BASE_ADDR, 64'h0},
  parameter logic [NUM_CH*3-1:0]      CH_RD_CTRL = {3'b101, 3'b000},
  parameter int                       MAX_OUTST  = 2,
  localparam int                      CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic [CHW-1:0]  req_ch,
  output logic [2:0]      req_rd_ctrl,
  output logic            req_epoch,
  input  logic            rsp_valid,
  output logic [XLEN-1:0] pc_IFP,
  output logic [3:0]      outst_cnt,
  output logic            misalign_err,
  output logic            dbg_state_o
);

  // Handshake: a request transfers on a cycle where req_valid && req_ready; once
  // raised it holds with stable payload until that transfer or a redirect.

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(PC_STEP - 1);
  localparam logic [XLEN-1:0] STEP_V   = XLEN'(PC_STEP);
  localparam logic [3:0]      MAX_V    = 4'(MAX_OUTST);

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_ifp_q, pc_ifp_d;
  logic            epoch_q, epoch_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            misalign_q, misalign_d;
  logic            accept;
  logic            rsp_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      pc_ifp_q   <= RESET_PC;
      epoch_q    <= 1'b0;
      cnt_q      <= 4'd0;
      pend_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_ifp_q   <= pc_ifp_d;
      epoch_q    <= epoch_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      misalign_q <= misalign_d;
    end
  end

  // Channel decode: bases ascend, so the last base not above the PC wins.
  always_comb begin
    req_ch = '0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (fetch_pc_q >= CH_BASE[i*XLEN +: XLEN]) req_ch = CHW'(i);
    end
    req_rd_ctrl = CH_RD_CTRL[int'(req_ch)*3 +: 3];
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_ifp_d   = pc_ifp_q;
    epoch_d    = epoch_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    // A pending request ignores stall; a fresh one needs a free slot.
    req_valid = (state_q == RUN) && (pend_q || (!stall && (cnt_q < MAX_V)));
    accept    = req_valid && req_ready;
    rsp_dec   = rsp_valid && (cnt_q != 4'd0);
    pend_d    = req_valid && !req_ready && !redirect_valid;

    case ({accept, rsp_dec})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase

    if (accept) begin
      pc_ifp_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + STEP_V;
    end

    // Redirect overrides the sequential increment; the accepted request keeps the old epoch.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~LOW_MASK;
      epoch_d    = ~epoch_q;
      misalign_d = |(redirect_pc & LOW_MASK);
    end
  end

  assign req_addr     = fetch_pc_q;
  assign req_epoch    = epoch_q;
  assign pc_IFP       = pc_ifp_q;
  assign outst_cnt    = cnt_q;
  assign misalign_err = misalign_q;
  assign dbg_state_o  = logic'(state_q);

endmodule

// File: tb/tb_pipeline_ifp_gen.sv
// Scoreboarded bench for pipeline_ifp_gen: expected requests are queued as stimulus
// is driven and checked by a monitor whenever a request is accepted.
`ifndef DRAM_BASE_ADDR
`define DRAM_BASE_ADDR 64'h0000_0000_8000_0000
`endif

module tb_pipeline_ifp_gen;
  localparam int          W    = 69;
  localparam logic [63:0] DRAM = `DRAM_BASE_ADDR;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic [0:0]  req_ch;
  logic [2:0]  req_rd_ctrl;
  logic        req_epoch;
  logic        rsp_valid = 1'b0;
  logic [63:0] pc_IFP;
  logic [3:0]  outst_cnt;
  logic        misalign_err;
  logic        dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic acc_last = 1'b0;
  logic [W-1:0] exp_q[$];

  pipeline_ifp_gen dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_ch(req_ch), .req_rd_ctrl(req_rd_ctrl), .req_epoch(req_epoch),
    .rsp_valid(rsp_valid), .pc_IFP(pc_IFP), .outst_cnt(outst_cnt),
    .misalign_err(misalign_err), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pkt(logic [63:0] a, logic ch, logic [2:0] rc, logic ep);
    return {a, ch, rc, ep};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    acc_last = 1'b0;
    if (!reset && req_valid && req_ready) begin
      acc_last = 1'b1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_accept got addr=%0h epoch=%0d, queue empty", req_addr, req_epoch);
      end else begin
        e = exp_q.pop_front();
        if ({req_addr, req_ch, req_rd_ctrl, req_epoch} !== e) begin
          bad++;
          $display("FAIL accept_pkt got=%0h exp=%0h", {req_addr, req_ch, req_rd_ctrl, req_epoch}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic drive_until_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      rsp_valid = acc_last;
      n++;
    end
    req_ready = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got left=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic settle();
    req_ready = 1'b0;
    for (int i = 0; i < 8 && outst_cnt != 4'd0; i++) begin
      rsp_valid = 1'b1;
      tick();
    end
    rsp_valid = 1'b0;
    total++;
    if (outst_cnt !== 4'd0) begin bad++; $display("FAIL settle_cnt got=%0d exp=0", outst_cnt); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", req_valid); end
    total++; if (outst_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", outst_cnt); end
    total++; if (pc_IFP !== 64'h0) begin bad++; $display("FAIL rst_pc_ifp got=%0h exp=0", pc_IFP); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%0b exp=0", misalign_err); end
    total++; if (req_epoch !== 1'b0) begin bad++; $display("FAIL rst_epoch got=%0b exp=0", req_epoch); end
    total++; if (dbg_state_o !== 1'b0) begin bad++; $display("FAIL rst_state got=%0b exp=0", dbg_state_o); end
    exp_q.push_back(pkt(64'h0, 1'b0, 3'b000, 1'b0));
    exp_q.push_back(pkt(64'h4, 1'b0, 3'b000, 1'b0));
    exp_q.push_back(pkt(64'h8, 1'b0, 3'b000, 1'b0));
    reset = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%0b exp=0", req_valid); end
    tick();
    total++; if (dbg_state_o !== 1'b1) begin bad++; $display("FAIL run_state got=%0b exp=1", dbg_state_o); end
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b exp=1", req_valid); end
  endtask

  task automatic test_sequential();
    drive_until_empty(10);
    total++; if (pc_IFP !== 64'h8) begin bad++; $display("FAIL seq_pc_ifp got=%0h exp=8", pc_IFP); end
    settle();
    total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL seq_pending got=%0b exp=1", req_valid); end
    total++; if (req_addr !== 64'hC) begin bad++; $display("FAIL seq_next_addr got=%0h exp=c", req_addr); end
  endtask

  task automatic test_redirect_dram();
    redirect_valid = 1'b1;
    redirect_pc = DRAM + 64'h10;
    tick();
    redirect_valid = 1'b0;
    total++; if (req_addr !== DRAM + 64'h10) begin bad++; $display("FAIL rd_addr got=%0h exp=%0h", req_addr, DRAM + 64'h10); end
    total++; if (req_ch !== 1'b1) begin bad++; $display("FAIL rd_ch got=%0d exp=1", req_ch); end
    total++; if (req_rd_ctrl !== 3'b101) begin bad++; $display("FAIL rd_ctrl got=%0b exp=101", req_rd_ctrl); end
    total++; if (req_epoch !== 1'b1) begin bad++; $display("FAIL rd_epoch got=%0b exp=1", req_epoch); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rd_misalign got=%0b exp=0", misalign_err); end
    exp_q.push_back(pkt(DRAM + 64'h10, 1'b1, 3'b101, 1'b1));
    req_ready = 1'b1;
    drive_until_empty(10);
    total++; if (pc_IFP !== DRAM + 64'h10) begin bad++; $display("FAIL rd_pc_ifp got=%0h exp=%0h", pc_IFP, DRAM + 64'h10); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      total++;
      if (req_valid !== 1'b1 || req_addr !== DRAM + 64'h14) begin
        bad++;
        $display("FAIL hold_c%0d got v=%0b a=%0h exp v=1 a=%0h", i, req_valid, req_addr, DRAM + 64'h14);
      end
      tick();
      rsp_valid = 1'b0;
    end
    stall = 1'b0;
    total++; if (pc_IFP !== DRAM + 64'h10) begin bad++; $display("FAIL hold_pc_before got=%0h exp=%0h", pc_IFP, DRAM + 64'h10); end
    exp_q.push_back(pkt(DRAM + 64'h14, 1'b1, 3'b101, 1'b1));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    total++; if (pc_IFP !== DRAM + 64'h14) begin bad++; $display("FAIL hold_pc_after got=%0h exp=%0h", pc_IFP, DRAM + 64'h14); end
    settle();
  endtask

  task automatic test_max_outst();
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    total++; if (outst_cnt !== 4'd0) begin bad++; $display("FAIL underflow got=%0d exp=0", outst_cnt); end
    exp_q.push_back(pkt(DRAM + 64'h18, 1'b1, 3'b101, 1'b1));
    exp_q.push_back(pkt(DRAM + 64'h1C, 1'b1, 3'b101, 1'b1));
    req_ready = 1'b1;
    tick();
    tick();
    total++; if (outst_cnt !== 4'd2) begin bad++; $display("FAIL max_cnt got=%0d exp=2", outst_cnt); end
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL max_valid got=%0b exp=0", req_valid); end
    tick();
    total++; if (outst_cnt !== 4'd2) begin bad++; $display("FAIL max_hold_cnt got=%0d exp=2", outst_cnt); end
    rsp_valid = 1'b1;
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL no_bypass got=%0b exp=0", req_valid); end
    tick();
    rsp_valid = 1'b0;
    total++; if (outst_cnt !== 4'd1) begin bad++; $display("FAIL rsp_cnt got=%0d exp=1", outst_cnt); end
    total++; if (req_valid !== 1'b1 || req_addr !== DRAM + 64'h20) begin
      bad++; $display("FAIL resume got v=%0b a=%0h exp v=1 a=%0h", req_valid, req_addr, DRAM + 64'h20);
    end
    exp_q.push_back(pkt(DRAM + 64'h20, 1'b1, 3'b101, 1'b1));
    tick();
    req_ready = 1'b0;
    total++; if (outst_cnt !== 4'd2) begin bad++; $display("FAIL resume_cnt got=%0d exp=2", outst_cnt); end
    settle();
  endtask

  task automatic test_redirect_accept();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8;
    tick();
    redirect_valid = 1'b0;
    total++; if (req_epoch !== 1'b0 || req_addr !== 64'h8) begin
      bad++; $display("FAIL ra_setup got e=%0b a=%0h exp e=0 a=8", req_epoch, req_addr);
    end
    exp_q.push_back(pkt(64'h8, 1'b0, 3'b000, 1'b0));
    exp_q.push_back(pkt(64'h100, 1'b0, 3'b000, 1'b1));
    req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h102;
    tick();
    redirect_valid = 1'b0;
    req_ready = 1'b0;
    total++; if (outst_cnt !== 4'd1) begin bad++; $display("FAIL ra_cnt got=%0d exp=1", outst_cnt); end
    total++; if (pc_IFP !== 64'h8) begin bad++; $display("FAIL ra_pc_ifp got=%0h exp=8", pc_IFP); end
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL ra_misalign got=%0b exp=1", misalign_err); end
    total++; if (req_addr !== 64'h100 || req_epoch !== 1'b1) begin
      bad++; $display("FAIL ra_next got a=%0h e=%0b exp a=100 e=1", req_addr, req_epoch);
    end
    tick();
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL ra_pulse got=%0b exp=0", misalign_err); end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    total++; if (pc_IFP !== 64'h100) begin bad++; $display("FAIL ra_pc_ifp2 got=%0h exp=100", pc_IFP); end
    total++; if (outst_cnt !== 4'd2) begin bad++; $display("FAIL ra_cnt2 got=%0d exp=2", outst_cnt); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", req_valid); end
    total++; if (outst_cnt !== 4'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", outst_cnt); end
    total++; if (req_epoch !== 1'b0) begin bad++; $display("FAIL mid_epoch got=%0b exp=0", req_epoch); end
    total++; if (req_addr !== 64'h0) begin bad++; $display("FAIL mid_addr got=%0h exp=0", req_addr); end
    exp_q.push_back(pkt(64'h0, 1'b0, 3'b000, 1'b0));
    reset = 1'b0;
    req_ready = 1'b1;
    drive_until_empty(10);
    settle();
  endtask

  task automatic test_boot_redirect();
    reset = 1'b1;
    repeat (2) tick();
    exp_q.push_back(pkt(64'h40, 1'b0, 3'b000, 1'b1));
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    req_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total++; if (req_addr !== 64'h40 || req_epoch !== 1'b1) begin
      bad++; $display("FAIL boot_rd got a=%0h e=%0b exp a=40 e=1", req_addr, req_epoch);
    end
    drive_until_empty(10);
    settle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_dram();
    test_hold();
    test_max_outst();
    test_redirect_accept();
    test_reset_mid();
    test_boot_redirect();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL final_queue got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
